// File: rtl/ip_packet_rx_if.sv
// ============================================================================
//  Module   : ip_packet_rx_if
//  Purpose  : AXI-Stream style RX byte channel between the Ethernet MAC
//             (master) and the packet parser (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ip_packet_rx_if;
    logic [7:0] MAC_DATA_IN;
    logic       MAC_DATA_VALID;
    logic       MAC_DATA_READY;
    logic       MAC_DATA_LAST;
    logic       MAC_DATA_TUSER;

    // MAC side: drives bytes, observes back-pressure
    modport master (
        output MAC_DATA_IN,
        output MAC_DATA_VALID,
        output MAC_DATA_LAST,
        output MAC_DATA_TUSER,
        input  MAC_DATA_READY
    );

    // Parser side: consumes bytes, drives back-pressure
    modport slave (
        input  MAC_DATA_IN,
        input  MAC_DATA_VALID,
        input  MAC_DATA_LAST,
        input  MAC_DATA_TUSER,
        output MAC_DATA_READY
    );
endinterface

`default_nettype wire

// File: rtl/ip_packet_rx.sv
// ============================================================================
//  Module   : ip_packet_rx
//  Purpose  : Parses Ethernet/IPv4 request frames from the MAC RX stream,
//             validates them against the accelerator's own addresses and
//             holds the sender's MAC/IP/2-byte message until acknowledged.
//             Rejected frames are counted in a saturating drop counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_packet_rx #(
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [31:0]               ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]               ACCELERATOR_MAC_ADDRESS,
    ip_packet_rx_if.slave             mac,
    output logic [47:0]               SENDER_MAC_ADDRESS,
    output logic [31:0]               SENDER_IP_ADDRESS,
    output logic [15:0]               SENDER_MESSAGE,
    output logic                      MESSAGE_VALID,
    input  logic                      MESSAGE_ACK,
    output logic [DROP_CNT_WIDTH-1:0] DROP_COUNT
);

    typedef enum logic [2:0] {
        ST_ETH_HDR = 3'd0,
        ST_IP_HDR  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic        r_bad;
    logic        r_uc_miss;
    logic        r_bc_miss;
    logic [7:0]  r_hi;
    logic [15:0] r_csum;
    logic [47:0] r_src_mac;
    logic [31:0] r_src_ip;
    logic [15:0] r_msg;

    logic        w_ready;
    logic        w_beat;
    logic        w_last;
    logic [7:0]  w_data;
    logic        w_accept;
    logic        w_drop;
    logic        w_chk_fail;
    logic        w_uc_miss;
    logic        w_bc_miss;
    logic [7:0]  w_exp_mac;
    logic [7:0]  w_exp_ip;
    logic [15:0] w_csum_base;
    logic [16:0] w_csum_sum;
    logic [15:0] w_csum_nxt;
    logic [15:0] w_msg_nxt;

    // The parser only back-pressures while a message awaits acknowledgement
    assign w_ready            = (r_state != ST_HOLD);
    assign mac.MAC_DATA_READY = w_ready;
    assign w_beat             = mac.MAC_DATA_VALID & w_ready;
    assign w_last             = mac.MAC_DATA_LAST;
    assign w_data             = mac.MAC_DATA_IN;

    // Expected destination MAC / IP byte for the current header position
    always_comb begin
        w_exp_mac = 8'h00;
        w_exp_ip  = 8'h00;
        case (r_cnt)
            6'd0:    w_exp_mac = ACCELERATOR_MAC_ADDRESS[47:40];
            6'd1:    w_exp_mac = ACCELERATOR_MAC_ADDRESS[39:32];
            6'd2:    w_exp_mac = ACCELERATOR_MAC_ADDRESS[31:24];
            6'd3:    w_exp_mac = ACCELERATOR_MAC_ADDRESS[23:16];
            6'd4:    w_exp_mac = ACCELERATOR_MAC_ADDRESS[15:8];
            6'd5:    w_exp_mac = ACCELERATOR_MAC_ADDRESS[7:0];
            default: w_exp_mac = 8'h00;
        endcase
        case (r_cnt)
            6'd16:   w_exp_ip = ACCELERATOR_IP_ADDRESS[31:24];
            6'd17:   w_exp_ip = ACCELERATOR_IP_ADDRESS[23:16];
            6'd18:   w_exp_ip = ACCELERATOR_IP_ADDRESS[15:8];
            6'd19:   w_exp_ip = ACCELERATOR_IP_ADDRESS[7:0];
            default: w_exp_ip = 8'h00;
        endcase
    end

    // Running ones'-complement header sum; a word completes on each odd byte
    always_comb begin
        w_csum_base = (r_cnt == 6'd1) ? 16'h0000 : r_csum;
        w_csum_sum  = {1'b0, w_csum_base} + {1'b0, r_hi, w_data};
        w_csum_nxt  = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
        // unicast and broadcast matches are tracked independently over bytes 0-5
        w_uc_miss   = ((r_cnt == 6'd0) ? 1'b0 : r_uc_miss) | (w_data != w_exp_mac);
        w_bc_miss   = ((r_cnt == 6'd0) ? 1'b0 : r_bc_miss) | (w_data != 8'hFF);
        w_msg_nxt   = (r_state == ST_PAYLOAD) ? {r_msg[7:0], w_data} : r_msg;
    end

    // Next-state, header checks and accept/drop decision
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_chk_fail  = 1'b0;
        case (r_state)
            ST_ETH_HDR: begin
                if (w_beat) begin
                    if (r_cnt == 6'd5 && w_uc_miss && w_bc_miss) w_chk_fail = 1'b1;
                    if (r_cnt == 6'd12 && w_data != 8'h08)        w_chk_fail = 1'b1;
                    if (r_cnt == 6'd13 && w_data != 8'h00)        w_chk_fail = 1'b1;
                    if (w_last)                 w_drop      = 1'b1;
                    else if (r_cnt == 6'd13)    w_state_nxt = ST_IP_HDR;
                end
            end
            ST_IP_HDR: begin
                if (w_beat) begin
                    if (r_cnt == 6'd0 && w_data != 8'h45)              w_chk_fail = 1'b1;
                    if (r_cnt == 6'd3 && {r_hi, w_data} < 16'd22)      w_chk_fail = 1'b1;
                    if (r_cnt >= 6'd16 && r_cnt <= 6'd19 && w_data != w_exp_ip)
                        w_chk_fail = 1'b1;
                    if (r_cnt == 6'd19 && w_csum_nxt != 16'hFFFF)      w_chk_fail = 1'b1;
                    if (w_last)                 w_drop      = 1'b1;
                    else if (r_cnt == 6'd19)    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_beat) begin
                    if (w_last) begin
                        if (r_cnt == 6'd1 && !r_bad && !mac.MAC_DATA_TUSER) w_accept = 1'b1;
                        else                                                 w_drop   = 1'b1;
                    end else if (r_cnt == 6'd1) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_beat && w_last) begin
                    if (!r_bad && !mac.MAC_DATA_TUSER) w_accept = 1'b1;
                    else                               w_drop   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (MESSAGE_ACK) w_state_nxt = ST_ETH_HDR;
            end
            default: w_state_nxt = ST_ETH_HDR;
        endcase
        if (w_accept)    w_state_nxt = ST_HOLD;
        else if (w_drop) w_state_nxt = ST_ETH_HDR;
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) r_state <= ST_ETH_HDR;
        else         r_state <= w_state_nxt;
    end

    // Byte position within the current section; restarts per section and per frame
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET)                                              r_cnt <= 6'd0;
        else if ((w_state_nxt != r_state) || (w_beat && w_last))  r_cnt <= 6'd0;
        else if (w_beat)                                          r_cnt <= r_cnt + 6'd1;
    end

    // Field capture, checksum accumulation and the sticky bad-frame flag
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_bad     <= 1'b0;
            r_uc_miss <= 1'b0;
            r_bc_miss <= 1'b0;
            r_hi      <= 8'h00;
            r_csum    <= 16'h0000;
            r_src_mac <= 48'h0;
            r_src_ip  <= 32'h0;
            r_msg     <= 16'h0000;
        end else begin
            if (w_drop)          r_bad <= 1'b0;
            else if (w_chk_fail) r_bad <= 1'b1;
            if (w_beat) begin
                r_hi <= w_data;
                if (r_state == ST_ETH_HDR) begin
                    if (r_cnt < 6'd6) begin
                        r_uc_miss <= w_uc_miss;
                        r_bc_miss <= w_bc_miss;
                    end
                    if (r_cnt >= 6'd6 && r_cnt <= 6'd11)
                        r_src_mac <= {r_src_mac[39:0], w_data};
                end
                if (r_state == ST_IP_HDR) begin
                    if (r_cnt[0]) r_csum <= w_csum_nxt;
                    if (r_cnt >= 6'd12 && r_cnt <= 6'd15)
                        r_src_ip <= {r_src_ip[23:0], w_data};
                end
                if (r_state == ST_PAYLOAD) r_msg <= w_msg_nxt;
            end
        end
    end

    // Message holding registers: loaded on accept, released on acknowledge
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            SENDER_MAC_ADDRESS <= 48'h0;
            SENDER_IP_ADDRESS  <= 32'h0;
            SENDER_MESSAGE     <= 16'h0000;
            MESSAGE_VALID      <= 1'b0;
        end else if (w_accept) begin
            SENDER_MAC_ADDRESS <= r_src_mac;
            SENDER_IP_ADDRESS  <= r_src_ip;
            SENDER_MESSAGE     <= w_msg_nxt;
            MESSAGE_VALID      <= 1'b1;
        end else if (r_state == ST_HOLD && MESSAGE_ACK) begin
            MESSAGE_VALID      <= 1'b0;
        end
    end

    // Saturating count of discarded frames
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET)
            DROP_COUNT <= '0;
        else if (w_drop && !(&DROP_COUNT))
            DROP_COUNT <= DROP_COUNT + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end

endmodule

`default_nettype wire

// File: tb/tb_ip_packet_rx.sv
// ============================================================================
//  Module   : tb_ip_packet_rx
//  Purpose  : Directed self-checking bench for ip_packet_rx.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ip_packet_rx;

    logic        ACLK   = 1'b0;
    logic        ARESET = 1'b0;
    logic [31:0] acc_ip  = 32'h0A000002;
    logic [47:0] acc_mac = 48'h020000000001;
    logic [47:0] snd_mac;
    logic [31:0] snd_ip;
    logic [15:0] snd_msg;
    logic        msg_valid;
    logic        msg_ack = 1'b0;
    logic [15:0] drops;

    int n_vec = 0;
    int n_err = 0;

    logic [287:0] good_frame = 288'h020000000001_0200000000AA_0800_45000016_00000000_800426E2_0A000001_0A000002_025A;
    logic [7:0]   frm[$];

    ip_packet_rx_if mac_if();

    ip_packet_rx #(.DROP_CNT_WIDTH(16)) dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (acc_ip),
        .ACCELERATOR_MAC_ADDRESS (acc_mac),
        .mac                     (mac_if),
        .SENDER_MAC_ADDRESS      (snd_mac),
        .SENDER_IP_ADDRESS       (snd_ip),
        .SENDER_MESSAGE          (snd_msg),
        .MESSAGE_VALID           (msg_valid),
        .MESSAGE_ACK             (msg_ack),
        .DROP_COUNT              (drops)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_good();
        frm.delete();
        for (int i = 0; i < 36; i++) frm.push_back(good_frame[287 - 8*i -: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic tuser);
        int w;
        @(negedge ACLK);
        mac_if.MAC_DATA_IN    = b;
        mac_if.MAC_DATA_VALID = 1'b1;
        mac_if.MAC_DATA_LAST  = last;
        mac_if.MAC_DATA_TUSER = tuser;
        w = 0;
        while (!mac_if.MAC_DATA_READY && w < 50) begin
            @(negedge ACLK);
            w++;
        end
        if (w >= 50) begin
            n_err++;
            $error("FAIL ready_timeout: observed READY=0 expected READY=1 within 50 cycles");
        end
    endtask

    task automatic idle();
        @(negedge ACLK);
        mac_if.MAC_DATA_VALID = 1'b0;
        mac_if.MAC_DATA_LAST  = 1'b0;
        mac_if.MAC_DATA_TUSER = 1'b0;
    endtask

    // Sends frm[first..last_idx]; LAST (and optional TUSER) on last_idx
    task automatic send_frame(input int last_idx, input logic tuser, input int first);
        for (int i = first; i <= last_idx; i++)
            send_byte(frm[i], (i == last_idx), tuser && (i == last_idx));
        idle();
    endtask

    task automatic chk_accepted(input string tag, input logic [15:0] exp_drops);
        chk({tag, "_valid"}, msg_valid, 1);
        chk({tag, "_msg"},   snd_msg, 16'h025A);
        chk({tag, "_ip"},    snd_ip, 32'h0A000001);
        chk({tag, "_mac"},   snd_mac, 48'h0200000000AA);
        chk({tag, "_drops"}, drops, exp_drops);
        chk({tag, "_ready"}, mac_if.MAC_DATA_READY, 0);
    endtask

    task automatic ack_pulse(input string tag);
        @(negedge ACLK);
        msg_ack = 1'b1;
        @(negedge ACLK);
        msg_ack = 1'b0;
        chk({tag, "_ack_valid"}, msg_valid, 0);
        chk({tag, "_ack_ready"}, mac_if.MAC_DATA_READY, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, msg_valid, 0);
        chk({tag, "_drops"}, drops, 0);
        chk({tag, "_msg"},   snd_msg, 0);
        chk({tag, "_ip"},    snd_ip, 0);
        chk({tag, "_mac"},   snd_mac, 0);
        chk({tag, "_ready"}, mac_if.MAC_DATA_READY, 1);
    endtask

    initial begin
        mac_if.MAC_DATA_IN    = 8'h00;
        mac_if.MAC_DATA_VALID = 1'b0;
        mac_if.MAC_DATA_LAST  = 1'b0;
        mac_if.MAC_DATA_TUSER = 1'b0;
        repeat (3) @(negedge ACLK);
        chk_reset("reset");
        ARESET = 1'b1;

        // 1: good unicast frame
        make_good();
        send_frame(35, 1'b0, 0);
        chk_accepted("t1", 16'd0);
        ack_pulse("t1");

        // 2: broadcast destination, 4 padding bytes, then held off while the MAC offers more
        make_good();
        for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
        for (int i = 0; i < 4; i++) frm.push_back(8'hC3);
        send_frame(39, 1'b0, 0);
        chk_accepted("t2", 16'd0);
        make_good();
        @(negedge ACLK);
        mac_if.MAC_DATA_IN    = frm[0];
        mac_if.MAC_DATA_VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            chk("t2_hold_ready", mac_if.MAC_DATA_READY, 0);
            chk("t2_hold_valid", msg_valid, 1);
            chk("t2_hold_msg",   snd_msg, 16'h025A);
        end
        msg_ack = 1'b1;
        @(negedge ACLK);
        msg_ack = 1'b0;
        chk("t2_ack_valid", msg_valid, 0);
        chk("t2_ack_ready", mac_if.MAC_DATA_READY, 1);
        mac_if.MAC_DATA_VALID = 1'b0;
        send_frame(35, 1'b0, 0);
        chk_accepted("t2b", 16'd0);
        ack_pulse("t2b");

        // 3: bad checksum dropped, following good frame accepted
        make_good();
        frm[25] = 8'hE3;
        send_frame(35, 1'b0, 0);
        chk("t3_valid", msg_valid, 0);
        chk("t3_drops", drops, 1);
        make_good();
        send_frame(35, 1'b0, 0);
        chk_accepted("t3b", 16'd1);
        ack_pulse("t3b");

        // 4: fresh reset, then four different rejections
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk_reset("t4_reset");
        ARESET = 1'b1;
        make_good();
        send_frame(24, 1'b0, 0);
        chk("t4_trunc_valid", msg_valid, 0);
        chk("t4_trunc_drops", drops, 1);
        make_good();
        frm[33] = 8'h03;
        send_frame(35, 1'b0, 0);
        chk("t4_dstip_valid", msg_valid, 0);
        chk("t4_dstip_drops", drops, 2);
        make_good();
        frm[12] = 8'h86;
        frm[13] = 8'hDD;
        send_frame(35, 1'b0, 0);
        chk("t4_etype_valid", msg_valid, 0);
        chk("t4_etype_drops", drops, 3);
        make_good();
        send_frame(35, 1'b1, 0);
        chk("t4_tuser_valid", msg_valid, 0);
        chk("t4_tuser_drops", drops, 4);

        // 5: reset in the middle of the Ethernet header
        make_good();
        for (int i = 0; i < 8; i++) send_byte(frm[i], 1'b0, 1'b0);
        @(negedge ACLK);
        mac_if.MAC_DATA_VALID = 1'b0;
        ARESET = 1'b0;
        #1;
        chk_reset("t5_reset");
        @(negedge ACLK);
        ARESET = 1'b1;
        send_frame(35, 1'b0, 8);
        chk("t5_rest_valid", msg_valid, 0);
        chk("t5_rest_drops", drops, 1);
        make_good();
        send_frame(35, 1'b0, 0);
        chk_accepted("t5b", 16'd1);
        ack_pulse("t5b");

        // 6: drop counter saturation using one-byte frames
        for (int i = 0; i < 65534; i++) begin
            @(negedge ACLK);
            mac_if.MAC_DATA_IN    = 8'h00;
            mac_if.MAC_DATA_VALID = 1'b1;
            mac_if.MAC_DATA_LAST  = 1'b1;
        end
        idle();
        chk("t6_full", drops, 16'hFFFF);
        make_good();
        frm[25] = 8'hE3;
        send_frame(35, 1'b0, 0);
        chk("t6_sat", drops, 16'hFFFF);
        chk("t6_valid", msg_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
